// File: rtl/gemm_tile_engine.sv
// GRID_SIZE x GRID_SIZE tile engine: fetches A/B (and C when accumulating) from scratch memory,
// computes A*B (optionally B transposed) or A+B, and writes C back. GRID_SIZE must be at least 2.
module gemm_tile_engine #(
  parameter int NUM_SIZE   = 16,
  parameter int BUFFER_LEN = 32,
  parameter int GRID_SIZE  = 2,
  localparam int ADDR_W    = $clog2(BUFFER_LEN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [9+3*ADDR_W-1:0]   cmd_instr,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_rd_en,
  input  logic [NUM_SIZE-1:0]     mem_rdata,
  output logic                    mem_wr_en,
  output logic [NUM_SIZE-1:0]     mem_wdata
);
  localparam int IW     = 9 + 3*ADDR_W;
  localparam int G2     = GRID_SIZE*GRID_SIZE;
  localparam int G3     = G2*GRID_SIZE;
  localparam int NBUF   = 3*G2;
  localparam int ACC_W  = 2*NUM_SIZE + $clog2(GRID_SIZE) + 1;
  localparam int CNT_W  = $clog2(((G3 > NBUF) ? G3 : NBUF) + 1);
  localparam int IDX_W  = $clog2(NBUF);
  localparam int AIDX_W = $clog2(G2);
  localparam logic [5:0] OP_NOP    = 6'd0;
  localparam logic [5:0] OP_MATMUL = 6'd1;
  localparam logic [5:0] OP_EWADD  = 6'd2;
  localparam logic [NUM_SIZE-1:0] MAX_VAL = '1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_COMPUTE, S_STORE, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [5:0]            r_op;
  logic [ADDR_W-1:0]     r_addr_a, r_addr_b, r_addr_c;
  logic [2:0]            r_mode;
  logic                  r_err_flag;
  logic [CNT_W-1:0]      r_cnt, w_cnt;
  logic                  r_pend;
  logic [IDX_W-1:0]      r_rd_idx, w_rd_idx, r_pend_idx;
  logic [NUM_SIZE-1:0]   r_opnd [NBUF];
  logic [ACC_W-1:0]      r_acc [G2];
  logic                  r_cmd_ready, r_busy, r_done, r_err, r_rd_en, r_wr_en;
  logic [ADDR_W-1:0]     r_addr, w_addr, w_ld_addr;
  logic [NUM_SIZE-1:0]   r_wdata, w_wdata;
  logic                  w_rd_en, w_wr_en;

  logic [5:0]            w_cmd_op;
  logic [ADDR_W-1:0]     w_cmd_a, w_cmd_b, w_cmd_c;
  logic [2:0]            w_cmd_mode;
  logic                  w_cmd_legal;
  logic [CNT_W-1:0]      w_n_load, w_n_comp;
  logic [IDX_W-1:0]      w_a_idx, w_b_idx, w_c_idx;
  logic [AIDX_W-1:0]     w_acc_idx;
  logic [ACC_W-1:0]      w_acc_val, w_cterm;

  assign w_cmd_op    = cmd_instr[IW-1 -: 6];
  assign w_cmd_a     = cmd_instr[3+3*ADDR_W-1 -: ADDR_W];
  assign w_cmd_b     = cmd_instr[3+2*ADDR_W-1 -: ADDR_W];
  assign w_cmd_c     = cmd_instr[3+ADDR_W-1 -: ADDR_W];
  assign w_cmd_mode  = cmd_instr[2:0];
  assign w_cmd_legal = (w_cmd_op == OP_MATMUL) || (w_cmd_op == OP_EWADD);
  assign w_n_load    = r_mode[0] ? CNT_W'(NBUF) : CNT_W'(2*G2);
  assign w_n_comp    = (r_op == OP_EWADD) ? CNT_W'(G2) : CNT_W'(G3);

  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign mem_addr  = r_addr;
  assign mem_rd_en = r_rd_en;
  assign mem_wr_en = r_wr_en;
  assign mem_wdata = r_wdata;

  // Saturation or wrap is applied only here, on the finished accumulator value.
  function automatic logic [NUM_SIZE-1:0] f_finalize(input logic [ACC_W-1:0] v, input logic sat);
    if (sat && (v > ACC_W'(MAX_VAL))) f_finalize = MAX_VAL;
    else                              f_finalize = v[NUM_SIZE-1:0];
  endfunction

  // Operand buffer layout is A, then B, then C; each region is addressed modulo the memory size.
  always_comb begin
    if (r_cnt < CNT_W'(G2))          w_ld_addr = r_addr_a + ADDR_W'(r_cnt);
    else if (r_cnt < CNT_W'(2*G2))   w_ld_addr = r_addr_b + ADDR_W'(r_cnt - CNT_W'(G2));
    else                             w_ld_addr = r_addr_c + ADDR_W'(r_cnt - CNT_W'(2*G2));
  end

  always_comb begin
    w_next   = r_state;
    w_cnt    = r_cnt;
    w_rd_en  = 1'b0;
    w_wr_en  = 1'b0;
    w_addr   = r_addr;
    w_wdata  = r_wdata;
    w_rd_idx = r_rd_idx;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid && w_cmd_legal) begin
          w_next   = S_LOAD;
          w_rd_en  = 1'b1;
          w_addr   = w_cmd_a;
          w_rd_idx = '0;
          w_cnt    = CNT_W'(1);
        end else if (cmd_valid) begin
          w_next = S_DONE;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_LOAD: begin
        if (r_cnt < w_n_load) begin
          w_rd_en  = 1'b1;
          w_addr   = w_ld_addr;
          w_rd_idx = IDX_W'(r_cnt);
          w_cnt    = r_cnt + CNT_W'(1);
        end else begin
          w_next = S_DRAIN;
          w_cnt  = '0;
        end
      end
      S_DRAIN: begin
        w_next = S_COMPUTE;
        w_cnt  = '0;
      end
      S_COMPUTE: begin
        if (r_cnt == w_n_comp - CNT_W'(1)) begin
          w_next  = S_STORE;
          w_wr_en = 1'b1;
          w_addr  = r_addr_c;
          w_wdata = f_finalize(r_acc[0], r_mode[1]);
          w_cnt   = CNT_W'(1);
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_STORE: begin
        if (r_cnt < CNT_W'(G2)) begin
          w_wr_en = 1'b1;
          w_addr  = r_addr_c + ADDR_W'(r_cnt);
          w_wdata = f_finalize(r_acc[AIDX_W'(r_cnt)], r_mode[1]);
          w_cnt   = r_cnt + CNT_W'(1);
        end else begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // MATMUL walks (i, j, k) with k innermost; the first k step seeds from C (ACC) or zero.
  always_comb begin
    int v_n, v_i, v_j, v_k;
    v_n = int'(r_cnt);
    v_k = v_n % GRID_SIZE;
    v_j = (v_n / GRID_SIZE) % GRID_SIZE;
    v_i = v_n / G2;
    if (r_op == OP_EWADD) begin
      w_a_idx   = IDX_W'(v_n);
      w_b_idx   = IDX_W'(G2 + v_n);
      w_c_idx   = IDX_W'(2*G2 + v_n);
      w_acc_idx = AIDX_W'(v_n);
    end else begin
      w_a_idx   = IDX_W'(v_i*GRID_SIZE + v_k);
      w_b_idx   = r_mode[2] ? IDX_W'(G2 + v_j*GRID_SIZE + v_k) : IDX_W'(G2 + v_k*GRID_SIZE + v_j);
      w_c_idx   = IDX_W'(2*G2 + v_i*GRID_SIZE + v_j);
      w_acc_idx = AIDX_W'(v_i*GRID_SIZE + v_j);
    end
    w_cterm = r_mode[0] ? ACC_W'(r_opnd[w_c_idx]) : '0;
    if (r_op == OP_EWADD) begin
      w_acc_val = w_cterm + ACC_W'(r_opnd[w_a_idx]) + ACC_W'(r_opnd[w_b_idx]);
    end else if (v_k == 0) begin
      w_acc_val = w_cterm + ACC_W'(r_opnd[w_a_idx]) * ACC_W'(r_opnd[w_b_idx]);
    end else begin
      w_acc_val = r_acc[w_acc_idx] + ACC_W'(r_opnd[w_a_idx]) * ACC_W'(r_opnd[w_b_idx]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op        <= '0;
      r_addr_a    <= '0;
      r_addr_b    <= '0;
      r_addr_c    <= '0;
      r_mode      <= '0;
      r_err_flag  <= 1'b0;
      r_rd_idx    <= '0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rd_en     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt;
      r_rd_idx    <= w_rd_idx;
      r_cmd_ready <= (w_next == S_IDLE);
      r_busy      <= (w_next != S_IDLE);
      r_done      <= (r_state == S_DONE);
      r_err       <= (r_state == S_DONE) && r_err_flag;
      r_rd_en     <= w_rd_en;
      r_wr_en     <= w_wr_en;
      r_addr      <= w_addr;
      r_wdata     <= w_wdata;
      if (r_state == S_IDLE && cmd_valid) begin
        r_op       <= w_cmd_op;
        r_addr_a   <= w_cmd_a;
        r_addr_b   <= w_cmd_b;
        r_addr_c   <= w_cmd_c;
        r_mode     <= w_cmd_mode;
        r_err_flag <= !w_cmd_legal && (w_cmd_op != OP_NOP);
      end
    end
  end

  // Read data lands one cycle after its strobe; the tag of the read rides along with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend     <= 1'b0;
      r_pend_idx <= '0;
      for (int n = 0; n < NBUF; n++) r_opnd[n] <= '0;
      for (int n = 0; n < G2; n++)   r_acc[n]  <= '0;
    end else begin
      r_pend     <= r_rd_en;
      r_pend_idx <= r_rd_idx;
      if (r_pend) r_opnd[r_pend_idx] <= mem_rdata;
      if (r_state == S_COMPUTE) r_acc[w_acc_idx] <= w_acc_val;
    end
  end
endmodule
